// File: rtl/riscv_fetch_pkg.sv
// Shared definitions for the instruction fetch slice.
// Contents: fetch FSM state enum, datapath widths, default reset PC,
// the prefetch FIFO entry type and a PC word-alignment helper.
package riscv_fetch_pkg;

  localparam int XLEN   = 32;
  localparam int INST_W = 32;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_DRAIN
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  // Instructions are word aligned, so the two low PC bits are always zero.
  function automatic logic [XLEN-1:0] pc_align(input logic [XLEN-1:0] pc);
    return pc & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/riscv_ifetch_if.sv
// Bus bundle of the fetch unit: instruction-memory request/grant/response
// channel plus the valid/ready instruction channel towards decode.
//   imem_req/imem_addr      fetch -> memory, read request and word address
//   imem_gnt                memory -> fetch, request accepted
//   imem_rvalid/imem_rdata  memory -> fetch, in-order read response
//   inst_valid/pc/data      fetch -> decode, head of the prefetch buffer
//   inst_ready              decode -> fetch, head consumed
// master: the fetch unit side. slave: memory + decode side.
interface riscv_ifetch_if;
  import riscv_fetch_pkg::*;

  logic              imem_req;
  logic [XLEN-1:0]   imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [INST_W-1:0] imem_rdata;
  logic              inst_valid;
  logic              inst_ready;
  logic [XLEN-1:0]   inst_pc;
  logic [INST_W-1:0] inst_data;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    output inst_valid, inst_pc, inst_data,
    input  inst_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    input  inst_valid, inst_pc, inst_data,
    output inst_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO holding {pc, inst} entries.
//   clk, rst_n   clock, asynchronous active-low reset
//   i_push       write i_entry at the tail
//   i_entry      entry to write
//   i_pop        remove the head (ignored when empty)
//   i_flush      drop every entry; wins over push/pop
//   o_count      number of stored entries
//   o_valid      head entry present
//   o_head       head entry, driven straight from storage flops
// Push and pop in the same cycle at full occupancy is legal.
module fetch_fifo
  import riscv_fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  fetch_entry_t i_entry,
  input  logic         i_pop,
  input  logic         i_flush,
  output logic [CW-1:0] o_count,
  output logic         o_valid,
  output fetch_entry_t o_head
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_rdPtr;
  logic [AW-1:0] r_wrPtr;
  logic [CW-1:0] r_count;
  logic          w_pop;

  assign w_pop = i_pop && (r_count != '0);

  // Storage is cleared on reset so the head reads as all-zero until the
  // first push. DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_flush) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wrPtr] <= i_entry;
        r_wrPtr        <= r_wrPtr + AW'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + AW'(1);
      end
      r_count <= r_count + CW'(i_push) - CW'(w_pop);
    end
  end

  assign o_count = r_count;
  assign o_valid = (r_count != '0);
  assign o_head  = r_mem[r_rdPtr];

endmodule

// File: rtl/riscv_ifetch.sv
// Instruction fetch unit in front of the single-cycle RISC-V datapath.
// Issues pipelined word reads, buffers returned words with their PCs and
// hands them to decode; a redirect flushes the buffer and drops every
// response still in flight.
//   clk, rst_n       clock, asynchronous active-low reset
//   redirect_valid   taken branch/jump this cycle
//   redirect_pc      new fetch PC (low two bits ignored)
//   bus              riscv_ifetch_if.master: imem and decode channels
module riscv_ifetch
  import riscv_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  riscv_ifetch_if.master  bus
);

  localparam int          CW    = $clog2(DEPTH) + 1;
  localparam logic [CW:0] LIMIT = (CW + 1)'(DEPTH);

  fetch_state_e    r_state;
  logic [XLEN-1:0] r_fetchPc;
  logic [XLEN-1:0] r_respPc;
  logic [CW-1:0]   r_outstanding;
  logic [CW-1:0]   r_discardCnt;

  logic [CW-1:0]   w_count;
  logic            w_fifoValid;
  fetch_entry_t    w_head;
  fetch_entry_t    w_pushEntry;
  logic            w_pop;
  logic            w_req;
  logic            w_grant;
  logic            w_rsp;
  logic            w_keep;
  logic [CW:0]     w_occupancy;
  logic [CW-1:0]   w_outAfterRsp;
  logic [CW-1:0]   w_outstandingNext;
  logic [CW-1:0]   w_discardNext;
  logic [XLEN-1:0] w_redirectPc;

  assign w_redirectPc = pc_align(redirect_pc);
  assign w_pop        = w_fifoValid & bus.inst_ready;

  // Every granted request eventually needs a FIFO slot, so buffered plus
  // in-flight entries (less the one leaving this cycle) bound the issue.
  assign w_occupancy = {1'b0, r_outstanding} + {1'b0, w_count} - {{CW{1'b0}}, w_pop};
  assign w_req       = (r_state != ST_BOOT) && !redirect_valid && (w_occupancy < LIMIT);
  assign w_grant     = w_req & bus.imem_gnt;
  assign w_rsp       = bus.imem_rvalid;

  // Responses are kept only when no older stale response is pending and
  // no redirect is flushing the buffer in this very cycle.
  assign w_keep        = w_rsp && (r_discardCnt == '0) && !redirect_valid;
  assign w_outAfterRsp = r_outstanding - CW'(w_rsp);

  assign w_outstandingNext = r_outstanding + CW'(w_grant) - CW'(w_rsp);

  // On redirect every response not yet returned becomes stale; this
  // already includes any that were being discarded before.
  always_comb begin
    w_discardNext = r_discardCnt;
    if (redirect_valid) begin
      w_discardNext = w_outAfterRsp;
    end else if (w_rsp && (r_discardCnt != '0)) begin
      w_discardNext = r_discardCnt - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_BOOT;
      r_fetchPc     <= RESET_PC;
      r_respPc      <= RESET_PC;
      r_outstanding <= '0;
      r_discardCnt  <= '0;
    end else begin
      r_outstanding <= w_outstandingNext;
      r_discardCnt  <= w_discardNext;
      case (r_state)
        ST_BOOT:          r_state <= ST_RUN;
        ST_RUN, ST_DRAIN: r_state <= (w_discardNext != '0) ? ST_DRAIN : ST_RUN;
        default:          r_state <= ST_BOOT;
      endcase
      if (redirect_valid) begin
        r_fetchPc <= w_redirectPc;
        r_respPc  <= w_redirectPc;
      end else begin
        if (w_grant) begin
          r_fetchPc <= r_fetchPc + XLEN'(4);
        end
        if (w_keep) begin
          r_respPc <= r_respPc + XLEN'(4);
        end
      end
    end
  end

  assign w_pushEntry.pc   = r_respPc;
  assign w_pushEntry.inst = bus.imem_rdata;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_keep),
    .i_entry (w_pushEntry),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .o_count (w_count),
    .o_valid (w_fifoValid),
    .o_head  (w_head)
  );

  assign bus.imem_req   = w_req;
  assign bus.imem_addr  = r_fetchPc;
  assign bus.inst_valid = w_fifoValid;
  assign bus.inst_pc    = w_head.pc;
  assign bus.inst_data  = w_head.inst;

endmodule

// File: tb/tb_riscv_ifetch.sv
// Self-checking bench for riscv_ifetch. A behavioural memory answers
// granted reads in order after a random delay; the reference model only
// tracks "next PC to be requested" and "next PC to be delivered", both
// restarting at the redirect target, with instruction words derived from
// the address.
module tb_riscv_ifetch;
  import riscv_fetch_pkg::*;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  riscv_ifetch_if bus ();

  riscv_ifetch #(
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          rdy;
  } pend_t;

  pend_t       memQ[$];
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  int          lastRdy  = 0;
  int          gntPct   = 100;
  int          rdyPct   = 100;
  int          redirPct = 0;
  int          minDly   = 1;
  int          maxDly   = 1;
  int          grantCount = 0;
  logic [31:0] expPc    = RESET_PC;
  logic [31:0] expAddr  = RESET_PC;
  logic [31:0] lastGrantAddr = 32'h0;
  logic [31:0] holdAddr = 32'h0;
  bit          pendingHold = 1'b0;
  bit          emptyNext   = 1'b0;
  bit          sawWrap     = 1'b0;

  logic        sReq, sGnt, sRvalid, sValid, sReady, sRedir;
  logic [31:0] sAddr, sPc, sData;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Sample the settled cycle, check it, and advance the reference models.
  task automatic sampleCycle();
    int dly;
    int rdy;
    sReq    = bus.imem_req;
    sAddr   = bus.imem_addr;
    sGnt    = bus.imem_gnt;
    sRvalid = bus.imem_rvalid;
    sValid  = bus.inst_valid;
    sReady  = bus.inst_ready;
    sPc     = bus.inst_pc;
    sData   = bus.inst_data;
    sRedir  = redirect_valid;
    if (!rst_n) begin
      pendingHold = 1'b0;
      emptyNext   = 1'b0;
      return;
    end
    if (emptyNext) checkOutput("flush_empty", sValid, 1'b0);
    emptyNext = 1'b0;
    if (pendingHold && !sRedir) begin
      checkOutput("req_held", sReq, 1'b1);
      checkOutput("addr_held", sAddr, holdAddr);
    end
    pendingHold = 1'b0;
    if (sRedir) checkOutput("req_on_redirect", sReq, 1'b0);
    if (sReq && sGnt) begin
      checkOutput("grant_addr", sAddr, expAddr);
      checkOutput("outstanding_bound", memQ.size() < DEPTH, 1'b1);
      if (lastGrantAddr == 32'hFFFF_FFFC && sAddr == 32'h0) sawWrap = 1'b1;
      lastGrantAddr = sAddr;
      grantCount++;
      expAddr = expAddr + 32'd4;
      dly = int'($urandom_range(maxDly, minDly));
      rdy = cyc + dly;
      if (rdy <= lastRdy) rdy = lastRdy + 1;
      lastRdy = rdy;
      memQ.push_back('{sAddr, rdy});
    end else if (sReq) begin
      pendingHold = 1'b1;
      holdAddr    = sAddr;
    end
    if (sRvalid && memQ.size() > 0) void'(memQ.pop_front());
    if (sRedir) begin
      expPc     = redirect_pc & ~32'h3;
      expAddr   = redirect_pc & ~32'h3;
      emptyNext = 1'b1;
    end else if (sValid && sReady) begin
      checkOutput("inst_pc", sPc, expPc);
      checkOutput("inst_data", sData, memWord(expPc));
      expPc = expPc + 32'd4;
    end
  endtask

  // Drive the memory response, grant, ready and random redirect for the new cycle.
  task automatic applyStimulus();
    cyc++;
    redirect_valid = 1'b0;
    bus.imem_gnt   = ($urandom_range(99, 0) < gntPct);
    bus.inst_ready = ($urandom_range(99, 0) < rdyPct);
    if (rst_n && memQ.size() > 0 && memQ[0].rdy <= cyc) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = memWord(memQ[0].addr);
    end else begin
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = $urandom();
    end
    if (rst_n && redirPct > 0 && $urandom_range(99, 0) < redirPct) begin
      redirect_valid = 1'b1;
      redirect_pc    = $urandom();
    end
  endtask

  task automatic runCycle();
    @(negedge clk);
    sampleCycle();
    @(posedge clk);
    #1;
    applyStimulus();
  endtask

  task automatic doRedirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
  endtask

  initial begin
    int n;
    rst_n           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = 32'h0;
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'h0;
    bus.inst_ready  = 1'b0;

    // Reset values, then zero-wait streaming from RESET_PC.
    runCycle();
    runCycle();
    checkOutput("reset_req", sReq, 1'b0);
    checkOutput("reset_addr", sAddr, RESET_PC);
    checkOutput("reset_valid", sValid, 1'b0);
    checkOutput("reset_pc", sPc, 32'h0);
    checkOutput("reset_data", sData, 32'h0);
    rst_n = 1'b1;
    expPc = RESET_PC; expAddr = RESET_PC; lastRdy = cyc;
    runCycle();
    checkOutput("boot_no_req", sReq, 1'b0);
    runCycle();
    checkOutput("first_req", sReq, 1'b1);
    checkOutput("first_addr", sAddr, RESET_PC);
    runCycle();
    checkOutput("c2_not_valid", sValid, 1'b0);
    runCycle();
    checkOutput("c3_valid", sValid, 1'b1);
    for (int i = 0; i < 6; i++) begin
      runCycle();
      checkOutput("stream_valid", sValid, 1'b1);
      checkOutput("stream_req", sReq, 1'b1);
    end

    // Decode stalled: only DEPTH requests, FIFO holds 0x0 and 0x4.
    rdyPct = 0;
    runCycle();
    doRedirect(32'h0);
    grantCount = 0;
    repeat (10) runCycle();
    checkOutput("stall_grants", grantCount, DEPTH);
    checkOutput("stall_req", sReq, 1'b0);
    checkOutput("stall_valid", sValid, 1'b1);
    checkOutput("stall_head", sPc, 32'h0);
    rdyPct = 100;
    runCycle();
    runCycle();
    checkOutput("resume_req", sReq, 1'b1);
    checkOutput("resume_addr", sAddr, 32'h8);

    // Redirect with 0x8 and 0xC in flight.
    minDly = 3; maxDly = 3;
    runCycle();
    doRedirect(32'h0);
    n = 0;
    runCycle();
    while (!(memQ.size() == 2 && memQ[0].addr == 32'h8) && n < 50) begin
      runCycle();
      n++;
    end
    checkOutput("two_outstanding", memQ.size(), 2);
    doRedirect(32'h100);
    n = 0;
    while (expPc != 32'h110 && n < 60) begin runCycle(); n++; end
    checkOutput("redirect_progress", expPc, 32'h110);

    // Unaligned target, then redirect colliding with rvalid and pop.
    minDly = 1; maxDly = 1;
    runCycle();
    doRedirect(32'h203);
    runCycle();
    runCycle();
    checkOutput("align_req", sReq, 1'b1);
    checkOutput("align_addr", sAddr, 32'h200);
    repeat (5) runCycle();
    doRedirect(32'h300);
    runCycle();
    checkOutput("collide_rvalid", sRvalid, 1'b1);
    checkOutput("collide_pop", sValid & sReady, 1'b1);
    runCycle();
    checkOutput("collide_empty", sValid, 1'b0);
    n = 0;
    while (expPc != 32'h310 && n < 60) begin runCycle(); n++; end
    checkOutput("collide_progress", expPc, 32'h310);

    // Random grant, latency, backpressure and redirects.
    gntPct = 50; minDly = 1; maxDly = 4; rdyPct = 70; redirPct = 2;
    repeat (1500) runCycle();
    redirPct = 0;

    // Address wrap from 0xFFFF_FFFC to 0x0.
    runCycle();
    doRedirect(32'hFFFF_FFF0);
    sawWrap = 1'b0;
    n = 0;
    while (expPc != 32'h10 && n < 300) begin runCycle(); n++; end
    checkOutput("wrap_progress", expPc, 32'h10);
    checkOutput("wrap_seen", sawWrap, 1'b1);

    // Reset mid-traffic clears outputs immediately.
    gntPct = 100; minDly = 3; maxDly = 3; rdyPct = 0;
    repeat (8) runCycle();
    rst_n = 1'b0;
    #2;
    checkOutput("async_req", bus.imem_req, 1'b0);
    checkOutput("async_addr", bus.imem_addr, RESET_PC);
    checkOutput("async_valid", bus.inst_valid, 1'b0);
    checkOutput("async_pc", bus.inst_pc, 32'h0);
    checkOutput("async_data", bus.inst_data, 32'h0);
    memQ.delete();
    bus.imem_rvalid = 1'b0;
    rdyPct = 100; minDly = 1; maxDly = 1;
    runCycle();
    runCycle();
    rst_n = 1'b1;
    expPc = RESET_PC; expAddr = RESET_PC; lastRdy = cyc;
    runCycle();
    checkOutput("rst2_boot", sReq, 1'b0);
    runCycle();
    checkOutput("rst2_req", sReq, 1'b1);
    checkOutput("rst2_addr", sAddr, RESET_PC);
    n = 0;
    while (expPc != 32'h10 && n < 40) begin runCycle(); n++; end
    checkOutput("rst2_progress", expPc, 32'h10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/riscv_ifetch.md
# riscv_ifetch

Instruction fetch unit sitting directly upstream of the single-cycle RISC-V datapath. It issues pipelined word reads to an instruction-memory bus with a request/grant/response handshake, buffers returned words with their PCs in a small prefetch FIFO, and presents them to decode over a valid/ready interface. Branch/jump redirects from the datapath flush the buffer and discard in-flight responses.

## Interface
- RESET_PC, 32'h0000_0000, PC of first fetch after reset
- DEPTH, 2, prefetch FIFO entries and max outstanding requests (power of two, ≥2)

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- redirect_valid  in  1  taken branch/jump; flush and refetch
- redirect_pc  in  32  new fetch PC; bits [1:0] ignored (forced 0)
- imem_req  out  1  read request
- imem_addr  out  32  word address of request
- imem_gnt  in  1  request accepted when imem_req & imem_gnt
- imem_rvalid  in  1  response valid; in order, ≥1 cycle after grant
- imem_rdata  in  32  response word
- inst_valid  out  1  FIFO head valid
- inst_ready  in  1  decode consumes head when inst_valid & inst_ready
- inst_pc  out  32  PC of head instruction
- inst_data  out  32  head instruction word

## Operation
- Registers: fetch_pc (next address to request), resp_pc (PC of next kept response), outstanding (granted, not returned), discard_cnt (outstanding responses to drop), FIFO count.
- FSM states: BOOT, RUN, DRAIN. BOOT: one cycle after reset release, no request; → RUN. RUN → DRAIN on redirect when outstanding minus same-cycle rvalid > 0. DRAIN → RUN when discard_cnt reaches 0 with no new redirect.
- Issue rule (RUN or DRAIN): imem_req = 1 when outstanding + count − pop < DEPTH and no redirect this cycle; pop = inst_valid & inst_ready.
- Grant: fetch_pc += 4, outstanding += 1. imem_addr = fetch_pc; req/addr held stable until grant, except a redirect may withdraw them.
- Response: outstanding −= 1. If discard_cnt > 0: drop, discard_cnt −= 1. Else push {resp_pc, imem_rdata}, resp_pc += 4.
- Redirect: FIFO emptied, fetch_pc = resp_pc = {redirect_pc[31:2],2'b00}, discard_cnt = outstanding − (rvalid this cycle) + (discard_cnt contribution already counted), i.e. every response not yet returned is dropped. Response arriving in the redirect cycle is dropped; pop in that cycle is irrelevant.
- PC arithmetic modulo 2^32 (0xFFFF_FFFC + 4 wraps to 0).
- Push and pop in same cycle at full FIFO legal; issue rule guarantees no overflow.

## Timing
- Reset: imem_req 0, imem_addr RESET_PC, inst_valid 0, inst_pc 0, inst_data 0, all counters 0, state BOOT.
- Reset asserted mid-transaction: all state cleared immediately; bus responses after reset release for pre-reset grants are not supported (memory also reset).
- FIFO output registered: inst_valid rises the cycle after the accepted rvalid.
- Redirect at cycle N: imem_req 0 at N; request to redirect_pc at N+1; with zero-wait memory (gnt same cycle, rvalid next), inst_valid at N+3.
- Zero-wait memory and inst_ready held high: one instruction per cycle sustained with DEPTH=2.

## Structure
- Shared package riscv_fetch_pkg: fetch FSM state enum, XLEN=32, INST_W=32, default RESET_PC constant, fetch entry struct {pc, inst}.
- Sub-module fetch_fifo: synchronous FIFO of fetch entries, parameter DEPTH, push/pop/flush, count output, registered head.

## Test plan
- Reset release, gnt=1, rvalid one cycle after grant, inst_ready=1 → addresses 0x0,0x4,0x8… on consecutive cycles; inst_pc 0x0,0x4,0x8 with one instruction per cycle from cycle 3.
- inst_ready=0 for 10 cycles → at most DEPTH=2 grants, FIFO holds PCs 0x0,0x4, imem_req low; ready high → drains in order, fetch resumes at 0x8.
- Two requests outstanding (0x8,0xC), redirect to 0x100 → both responses dropped, next inst_pc 0x100, no 0x8/0xC delivered.
- Redirect_pc 0x203 → imem_addr 0x200; redirect in same cycle as rvalid and as pop → response dropped, FIFO empty next cycle.
- imem_gnt random 50%, rvalid delay 1–4 cycles → inst stream strictly sequential, matches memory model; fetch at 0xFFFF_FFFC followed by 0x0.
- rst_n asserted with FIFO full and requests outstanding → all outputs at reset values same cycle; first request to RESET_PC two cycles after release.
